// File: rtl/l1_tlb_pkg.sv
// l1_tlb_pkg: shared state encoding, default widths and entry layout for the L1 TLB.
package l1_tlb_pkg;
   localparam int L1_VPN_W = 27;
   localparam int L1_PPN_W = 20;
   typedef enum logic [1:0] {
      READY           = 2'd0,
      REQUEST         = 2'd1,
      WAIT            = 2'd2,
      WAIT_INVALIDATE = 2'd3
   } tlb_state_e;
   typedef struct packed {
      logic                valid;
      logic [L1_VPN_W-1:0] tag;
      logic [L1_PPN_W-1:0] ppn;
      logic                u;
      logic                r;
      logic                w;
      logic                x;
   } tlb_entry_t;
endpackage

// File: rtl/l1_tlb_refill_ctrl_if.sv
// l1_tlb_refill_ctrl_if: translation request/response and PTW refill bundle.
interface l1_tlb_refill_ctrl_if
   import l1_tlb_pkg::*;
#(
   parameter int VPN_W = L1_VPN_W,
   parameter int PPN_W = L1_PPN_W
);
   logic             io_req_valid;
   logic             io_req_ready;
   logic [VPN_W-1:0] io_req_bits_vpn;
   logic             io_req_bits_store;
   logic             io_req_bits_instruction;
   logic             io_resp_miss;
   logic [PPN_W-1:0] io_resp_ppn;
   logic             io_resp_xcpt_ld;
   logic             io_resp_xcpt_st;
   logic             io_resp_xcpt_if;
   logic             io_ptw_req_valid;
   logic             io_ptw_req_ready;
   logic [VPN_W-1:0] io_ptw_req_bits_addr;
   logic             io_ptw_resp_valid;
   logic             io_ptw_resp_bits_pf;
   logic [PPN_W-1:0] io_ptw_resp_bits_ppn;
   logic             io_ptw_resp_bits_u;
   logic             io_ptw_resp_bits_r;
   logic             io_ptw_resp_bits_w;
   logic             io_ptw_resp_bits_x;
   logic             io_ptw_invalidate;
   modport slave (
      input  io_req_valid, io_req_bits_vpn, io_req_bits_store, io_req_bits_instruction,
             io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_pf, io_ptw_resp_bits_ppn,
             io_ptw_resp_bits_u, io_ptw_resp_bits_r, io_ptw_resp_bits_w, io_ptw_resp_bits_x,
             io_ptw_invalidate,
      output io_req_ready, io_resp_miss, io_resp_ppn, io_resp_xcpt_ld, io_resp_xcpt_st,
             io_resp_xcpt_if, io_ptw_req_valid, io_ptw_req_bits_addr
   );
   modport master (
      output io_req_valid, io_req_bits_vpn, io_req_bits_store, io_req_bits_instruction,
             io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_pf, io_ptw_resp_bits_ppn,
             io_ptw_resp_bits_u, io_ptw_resp_bits_r, io_ptw_resp_bits_w, io_ptw_resp_bits_x,
             io_ptw_invalidate,
      input  io_req_ready, io_resp_miss, io_resp_ppn, io_resp_xcpt_ld, io_resp_xcpt_st,
             io_resp_xcpt_if, io_ptw_req_valid, io_ptw_req_bits_addr
   );
endinterface

// File: rtl/l1_tlb_entry_array.sv
// l1_tlb_entry_array: fully-associative entry storage with hit match, victim select and round-robin pointer.
module l1_tlb_entry_array
   import l1_tlb_pkg::*;
#(
   parameter int ENTRIES = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [L1_VPN_W-1:0] vpn_i,
   input  logic                flush_i,
   input  logic                we_i,
   input  tlb_entry_t          wdata_i,
   output logic                hit_o,
   output logic [L1_PPN_W-1:0] ppn_o,
   output logic [3:0]          perm_o
);
   localparam int IW = $clog2(ENTRIES);
   tlb_entry_t [ENTRIES-1:0] ent_q;
   logic [IW-1:0] rr_q, victim;
   logic any_inv;
   always_comb begin
      hit_o  = 1'b0;
      ppn_o  = '0;
      perm_o = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (ent_q[i].valid && ent_q[i].tag == vpn_i) begin
            hit_o  = 1'b1;
            ppn_o  = ent_q[i].ppn;
            perm_o = {ent_q[i].u, ent_q[i].r, ent_q[i].w, ent_q[i].x};
         end
   end
   // downward scan leaves the lowest-index invalid entry as the victim
   always_comb begin
      any_inv = 1'b0;
      victim  = rr_q;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!ent_q[i].valid) begin
            any_inv = 1'b1;
            victim  = IW'(i);
         end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ent_q <= '0;
         rr_q  <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
      end else if (we_i) begin
         ent_q[victim] <= wdata_i;
         if (!any_inv) rr_q <= rr_q + IW'(1);
      end
endmodule

// File: rtl/l1_tlb_refill_ctrl.sv
// l1_tlb_refill_ctrl: L1 TLB zero-latency lookup, permission checks and PTW refill FSM.
// Defining L1_TLB_PERF_CNT_EN adds saturating perf_hit_cnt/perf_miss_cnt outputs.
module l1_tlb_refill_ctrl
   import l1_tlb_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int VPN_W   = L1_VPN_W,
   parameter int PPN_W   = L1_PPN_W
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vm_enabled,
   input  logic        priv_s,
`ifdef L1_TLB_PERF_CNT_EN
   output logic [31:0] perf_hit_cnt,
   output logic [31:0] perf_miss_cnt,
`endif
   l1_tlb_refill_ctrl_if.slave bus
);
   tlb_state_e state_q;
   logic [VPN_W-1:0] r_vpn_q;
   logic ready_q, ptw_valid_q;
   logic hit, allowed, chk, we;
   logic [L1_PPN_W-1:0] hit_ppn;
   logic [3:0] perm;
   tlb_entry_t wdata;
   assign we    = state_q == WAIT && bus.io_ptw_resp_valid && !bus.io_ptw_invalidate;
   assign wdata = '{valid: 1'b1, tag: L1_VPN_W'(r_vpn_q), ppn: L1_PPN_W'(bus.io_ptw_resp_bits_ppn),
                    u: bus.io_ptw_resp_bits_u, r: bus.io_ptw_resp_bits_r & !bus.io_ptw_resp_bits_pf,
                    w: bus.io_ptw_resp_bits_w & !bus.io_ptw_resp_bits_pf,
                    x: bus.io_ptw_resp_bits_x & !bus.io_ptw_resp_bits_pf};
   l1_tlb_entry_array #(.ENTRIES(ENTRIES)) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .vpn_i   (L1_VPN_W'(bus.io_req_bits_vpn)),
      .flush_i (bus.io_ptw_invalidate),
      .we_i    (we),
      .wdata_i (wdata),
      .hit_o   (hit),
      .ppn_o   (hit_ppn),
      .perm_o  (perm)
   );
   assign allowed = priv_s ? !perm[3] : perm[3];
   assign chk     = ready_q && bus.io_req_valid && vm_enabled && hit;
   assign bus.io_req_ready         = ready_q;
   assign bus.io_resp_miss         = !ready_q || (vm_enabled && !hit);
   assign bus.io_resp_ppn          = vm_enabled ? PPN_W'(hit_ppn) : bus.io_req_bits_vpn[PPN_W-1:0];
   assign bus.io_resp_xcpt_ld      = chk && !bus.io_req_bits_store && !bus.io_req_bits_instruction && !(allowed && perm[2]);
   assign bus.io_resp_xcpt_st      = chk && bus.io_req_bits_store && !(allowed && perm[1]);
   assign bus.io_resp_xcpt_if      = chk && bus.io_req_bits_instruction && !(allowed && perm[0]);
   assign bus.io_ptw_req_valid     = ptw_valid_q;
   assign bus.io_ptw_req_bits_addr = r_vpn_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q     <= READY;
         r_vpn_q     <= '0;
         ready_q     <= 1'b1;
         ptw_valid_q <= 1'b0;
      end else
         case (state_q)
            READY:
               if (bus.io_req_valid && vm_enabled && !hit) begin
                  state_q     <= REQUEST;
                  r_vpn_q     <= bus.io_req_bits_vpn;
                  ready_q     <= 1'b0;
                  ptw_valid_q <= 1'b1;
               end
            REQUEST:
               if (bus.io_ptw_req_ready) begin
                  state_q     <= bus.io_ptw_invalidate ? WAIT_INVALIDATE : WAIT;
                  ptw_valid_q <= 1'b0;
               end else if (bus.io_ptw_invalidate) begin
                  state_q     <= READY;
                  ready_q     <= 1'b1;
                  ptw_valid_q <= 1'b0;
               end
            WAIT:
               if (bus.io_ptw_resp_valid) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end else if (bus.io_ptw_invalidate) state_q <= WAIT_INVALIDATE;
            WAIT_INVALIDATE:
               if (bus.io_ptw_resp_valid) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end
         endcase
`ifdef L1_TLB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         perf_hit_cnt  <= '0;
         perf_miss_cnt <= '0;
      end else if (ready_q && bus.io_req_valid && vm_enabled) begin
         if (hit) perf_hit_cnt <= (&perf_hit_cnt) ? perf_hit_cnt : perf_hit_cnt + 32'd1;
         else perf_miss_cnt <= (&perf_miss_cnt) ? perf_miss_cnt : perf_miss_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// tb_l1_tlb_refill_ctrl: directed plus randomized checks against an associative TLB reference model.
module tb_l1_tlb_refill_ctrl;
   logic clk = 1'b0;
   logic reset_n, vm_enabled, priv_s;
   int total = 0;
   int bad = 0;
   logic        m_v[8];
   logic [26:0] m_tag[8];
   logic [19:0] m_ppn[8];
   logic        m_u[8], m_r[8], m_w[8], m_x[8];
   int          m_rr;
`ifdef L1_TLB_PERF_CNT_EN
   logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif
   l1_tlb_refill_ctrl_if #(.VPN_W(27), .PPN_W(20)) bus ();
   l1_tlb_refill_ctrl #(.ENTRIES(8), .VPN_W(27), .PPN_W(20)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .vm_enabled (vm_enabled),
      .priv_s     (priv_s),
`ifdef L1_TLB_PERF_CNT_EN
      .perf_hit_cnt  (perf_hit_cnt),
      .perf_miss_cnt (perf_miss_cnt),
`endif
      .bus        (bus.slave)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_find(input logic [26:0] vpn);
      for (int i = 0; i < 8; i++) if (m_v[i] && m_tag[i] == vpn) return i;
      return -1;
   endfunction

   function automatic void m_flush();
      for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
   endfunction

   function automatic void m_refill(input logic [26:0] vpn, input logic pf, input logic [19:0] ppn, input logic [3:0] urwx);
      int idx = -1;
      for (int i = 7; i >= 0; i--) if (!m_v[i]) idx = i;
      if (idx < 0) begin
         idx  = m_rr;
         m_rr = (m_rr + 1) % 8;
      end
      m_v[idx] = 1'b1; m_tag[idx] = vpn; m_ppn[idx] = ppn; m_u[idx] = urwx[3];
      m_r[idx] = urwx[2] && !pf; m_w[idx] = urwx[1] && !pf; m_x[idx] = urwx[0] && !pf;
   endfunction

   task automatic cyc();
      @(negedge clk);
      bus.io_req_valid = 1'b0; bus.io_req_bits_store = 1'b0; bus.io_req_bits_instruction = 1'b0;
      bus.io_ptw_req_ready = 1'b0; bus.io_ptw_resp_valid = 1'b0; bus.io_ptw_resp_bits_pf = 1'b0;
      bus.io_ptw_resp_bits_ppn = '0; bus.io_ptw_resp_bits_u = 1'b0; bus.io_ptw_resp_bits_r = 1'b0;
      bus.io_ptw_resp_bits_w = 1'b0; bus.io_ptw_resp_bits_x = 1'b0; bus.io_ptw_invalidate = 1'b0;
   endtask

   task automatic access(input logic [26:0] vpn, input logic st, input logic ins, input logic ps,
                         input logic vm, output logic missed);
      int idx;
      logic h, al, er, ew, ex;
      cyc();
      bus.io_req_valid = 1'b1; bus.io_req_bits_vpn = vpn;
      bus.io_req_bits_store = st; bus.io_req_bits_instruction = ins;
      vm_enabled = vm; priv_s = ps;
      #1;
      idx = m_find(vpn);
      h = vm && idx >= 0;
      missed = vm && idx < 0;
      al = h && (ps ? !m_u[idx] : m_u[idx]);
      er = h && m_r[idx]; ew = h && m_w[idx]; ex = h && m_x[idx];
      chk("req_ready", bus.io_req_ready, 1'b1);
      chk("resp_miss", bus.io_resp_miss, missed);
      if (!vm) chk("ppn_bypass", bus.io_resp_ppn, vpn[19:0]);
      else if (h) chk("ppn_hit", bus.io_resp_ppn, m_ppn[idx]);
      chk("xcpt_ld", bus.io_resp_xcpt_ld, h && !st && !ins && !(al && er));
      chk("xcpt_st", bus.io_resp_xcpt_st, h && st && !(al && ew));
      chk("xcpt_if", bus.io_resp_xcpt_if, h && ins && !(al && ex));
   endtask

   // mode 0 refill, 1 cancel in REQUEST, 2 invalidate in WAIT,
   // 3 invalidate with req_ready, 4 invalidate with resp_valid
   task automatic ptw(input logic [26:0] vpn, input int mode, input int req_lat, input int resp_lat,
                      input logic pf, input logic [19:0] ppn, input logic [3:0] urwx);
      for (int k = 0; k < req_lat; k++) begin
         cyc(); #1;
         chk("ptw_valid_hold", bus.io_ptw_req_valid, 1'b1);
         chk("ptw_addr", bus.io_ptw_req_bits_addr, vpn);
         chk("busy_ready", bus.io_req_ready, 1'b0);
         chk("busy_miss", bus.io_resp_miss, 1'b1);
      end
      cyc();
      if (mode == 1) bus.io_ptw_invalidate = 1'b1;
      else begin
         bus.io_ptw_req_ready = 1'b1;
         bus.io_ptw_invalidate = mode == 3;
      end
      #1;
      chk("ptw_valid_req", bus.io_ptw_req_valid, 1'b1);
      if (mode == 1 || mode == 3) m_flush();
      if (mode != 1) begin
         if (mode == 2) begin
            cyc(); bus.io_ptw_invalidate = 1'b1; #1;
            m_flush();
         end
         for (int k = 0; k < resp_lat; k++) begin
            cyc(); #1;
            chk("wait_ptw_valid", bus.io_ptw_req_valid, 1'b0);
            chk("wait_ready", bus.io_req_ready, 1'b0);
            chk("wait_miss", bus.io_resp_miss, 1'b1);
         end
         cyc();
         bus.io_ptw_resp_valid = 1'b1; bus.io_ptw_resp_bits_pf = pf; bus.io_ptw_resp_bits_ppn = ppn;
         {bus.io_ptw_resp_bits_u, bus.io_ptw_resp_bits_r, bus.io_ptw_resp_bits_w, bus.io_ptw_resp_bits_x} = urwx;
         bus.io_ptw_invalidate = mode == 4;
         #1;
         chk("resp_ready", bus.io_req_ready, 1'b0);
         if (mode == 0) m_refill(vpn, pf, ppn, urwx);
         if (mode == 4) m_flush();
      end
      cyc(); #1;
      chk("back_ready", bus.io_req_ready, 1'b1);
      chk("back_ptw_valid", bus.io_ptw_req_valid, 1'b0);
   endtask

   task automatic flush_ready();
      cyc(); bus.io_ptw_invalidate = 1'b1; #1;
      chk("flush_ready", bus.io_req_ready, 1'b1);
      m_flush();
   endtask

   initial begin
      logic ms;
      logic [26:0] v;
      m_flush();
      m_rr = 0;
      reset_n = 1'b0; vm_enabled = 1'b0; priv_s = 1'b0;
      bus.io_req_bits_vpn = '0;
      cyc();
      #1;
      chk("rst_req_ready", bus.io_req_ready, 1'b1);
      chk("rst_ptw_valid", bus.io_ptw_req_valid, 1'b0);
      chk("rst_ptw_addr", bus.io_ptw_req_bits_addr, 27'h0);
      chk("rst_miss", bus.io_resp_miss, 1'b0);
      cyc();
      reset_n = 1'b1;
      // translation off: pass-through, stays READY
      access(27'h1234567, 1'b0, 1'b0, 1'b1, 1'b0, ms);
      chk("bypass_ppn_const", bus.io_resp_ppn, 20'h34567);
      cyc(); #1;
      chk("bypass_stays_ready", bus.io_req_ready, 1'b1);
      // miss, refill, then hit
      access(27'h00ABC, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      chk("abc_miss", ms, 1'b1);
      ptw(27'h00ABC, 0, 2, 1, 1'b0, 20'h55, 4'b0110);
      access(27'h00ABC, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      chk("abc_hit_ppn", bus.io_resp_ppn, 20'h55);
      chk("abc_hit_noxcpt", bus.io_resp_xcpt_ld, 1'b0);
      // permission faults
      access(27'h777, 1'b0, 1'b0, 1'b0, 1'b1, ms);
      ptw(27'h777, 0, 0, 0, 1'b0, 20'h777, 4'b1101);
      access(27'h777, 1'b1, 1'b0, 1'b0, 1'b1, ms);
      chk("u_store_fault", bus.io_resp_xcpt_st, 1'b1);
      access(27'h777, 1'b0, 1'b1, 1'b1, 1'b1, ms);
      chk("s_fetch_fault", bus.io_resp_xcpt_if, 1'b1);
      // fill nine VPNs into eight entries
      flush_ready();
      for (int i = 1; i <= 9; i++) begin
         access(27'h100 + 27'(i), 1'b0, 1'b0, 1'b1, 1'b1, ms);
         ptw(27'h100 + 27'(i), 0, i % 3, i % 2, 1'b0, 20'h200 + 20'(i), 4'b0111);
      end
      for (int i = 2; i <= 9; i++) begin
         access(27'h100 + 27'(i), 1'b0, 1'b0, 1'b1, 1'b1, ms);
         chk("fill_hit", ms, 1'b0);
      end
      access(27'h101, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      chk("fill_evicted", ms, 1'b1);
      ptw(27'h101, 0, 1, 1, 1'b0, 20'h201, 4'b0111);
      // invalidate during WAIT drops the refill
      access(27'h300, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      ptw(27'h300, 2, 0, 1, 1'b0, 20'h300, 4'b0111);
      for (int i = 0; i < 3; i++) begin
         v = (i == 0) ? 27'h300 : 27'h101 + 27'(i * 3);
         access(v, 1'b0, 1'b0, 1'b1, 1'b1, ms);
         chk("inval_all_miss", ms, 1'b1);
         ptw(v, 1, 0, 0, 1'b0, 20'h0, 4'b0);
      end
      // walk fault installs an entry with no r/w/x
      access(27'h10, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      ptw(27'h10, 0, 1, 2, 1'b1, 20'h99, 4'b0111);
      access(27'h10, 1'b0, 1'b0, 1'b1, 1'b1, ms);
      chk("pf_hit", ms, 1'b0);
      chk("pf_xcpt_ld", bus.io_resp_xcpt_ld, 1'b1);
      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         v = ($urandom_range(0, 9) == 0) ? 27'($urandom) : 27'($urandom_range(0, 11));
         access(v, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) != 0, ms);
         if (ms)
            ptw(v, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                20'($urandom), 4'($urandom));
         else if ($urandom_range(0, 24) == 0) flush_ready();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
